l2_bus_master: RTL and testbench

- Initiator side of the 8-cycle-slot snooping memory bus; the DRAM controller is the responder.
- Accepts one line request at a time from the L2 miss/writeback path and issues `CMD_BUSRD`, `CMD_BUSRDX` or `CMD_FLUSH` on the bus.
- Retries on nack.
- For reads, captures the 8-beat `CMD_FILL` response that carries its tag and hands the 64-byte line back to the cache.

---
 rtl/l2_bus_master_if.sv | 49 ++++
 rtl/l2_bus_master.sv | 162 ++++++++++++++++
 tb/tb_l2_bus_master.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_bus_master_if.sv
// Signal bundle between the L2 miss/writeback path, the snooping bus and the bus master.
// The master modport is the bus master's view; slave is the view of whatever
// surrounds it (cache side plus bus responder/arbiter).
interface l2_bus_master_if;
    // Cache request / response
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic         req_excl;
    logic [25:0]  req_addr;
    logic [511:0] req_wdata;
    logic         resp_valid;
    logic [25:0]  resp_addr;
    logic [511:0] resp_rdata;

    // Snooped bus inputs
    logic         bus_valid;
    logic         bus_nack;
    logic [2:0]   bus_cmd;
    logic [4:0]   bus_tag;
    logic [25:0]  bus_addr;
    logic [63:0]  bus_data;

    // Driven bus outputs and arbitration
    logic         master_bus_req;
    logic [2:0]   master_bus_cmd;
    logic [4:0]   master_bus_tag;
    logic [25:0]  master_bus_addr;
    logic [63:0]  master_bus_data;
    logic         bus_master_grant;

    modport master (
        input  req_valid, req_write, req_excl, req_addr, req_wdata,
        output req_ready, resp_valid, resp_addr, resp_rdata,
        input  bus_valid, bus_nack, bus_cmd, bus_tag, bus_addr, bus_data,
        output master_bus_req, master_bus_cmd, master_bus_tag, master_bus_addr,
        output master_bus_data,
        input  bus_master_grant
    );

    modport slave (
        output req_valid, req_write, req_excl, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_addr, resp_rdata,
        output bus_valid, bus_nack, bus_cmd, bus_tag, bus_addr, bus_data,
        input  master_bus_req, master_bus_cmd, master_bus_tag, master_bus_addr,
        input  master_bus_data,
        output bus_master_grant
    );
endinterface

// File: rtl/l2_bus_master.sv
// Initiator on the 8-cycle-slot snooping bus: takes one line request from the L2,
// arbitrates, drives BUSRD/BUSRDX/FLUSH for one slot, retries on nack and
// collects the tagged 8-beat fill for reads.
module l2_bus_master #(
    parameter logic [4:0] TAG = 5'd0
) (
    input logic           clk,
    input logic           rst,
    l2_bus_master_if.master io
);

    localparam logic [2:0] CMD_BUSRD  = 3'd1;
    localparam logic [2:0] CMD_BUSRDX = 3'd2;
    localparam logic [2:0] CMD_FLUSH  = 3'd3;
    localparam logic [2:0] CMD_FILL   = 3'd4;

    typedef enum logic [1:0] {IDLE, ARB, SEND, WAIT_FILL} state_t;

    state_t          state;
    logic [2:0]      slot;

    logic            lat_write;
    logic            lat_excl;
    logic [25:0]     lat_addr;
    logic [511:0]    lat_wdata;

    logic            smp_valid;
    logic [2:0]      smp_cmd;
    logic [4:0]      smp_tag;
    logic [25:0]     smp_addr;

    logic [7:0][63:0] cap;

    logic            req_ready_r;
    logic            bus_req_r;
    logic [2:0]      cmd_r;
    logic [4:0]      tag_r;
    logic [25:0]     addr_r;
    logic [63:0]     data_r;
    logic            resp_valid_r;
    logic [25:0]     resp_addr_r;
    logic [511:0]    resp_rdata_r;

    logic            fill_hit;
    logic [2:0]      cmd_sel;

    assign fill_hit = smp_valid && (smp_cmd == CMD_FILL) && (smp_tag == TAG) &&
                      (smp_addr == lat_addr);
    assign cmd_sel  = lat_write ? CMD_FLUSH : (lat_excl ? CMD_BUSRDX : CMD_BUSRD);

    assign io.req_ready       = req_ready_r;
    assign io.master_bus_req  = bus_req_r;
    assign io.master_bus_cmd  = cmd_r;
    assign io.master_bus_tag  = tag_r;
    assign io.master_bus_addr = addr_r;
    assign io.master_bus_data = data_r;
    assign io.resp_valid      = resp_valid_r;
    assign io.resp_addr       = resp_addr_r;
    assign io.resp_rdata      = resp_rdata_r;

    // Beat k of every slot lands in entry k; pure data path, so no reset
    always_ff @(posedge clk) begin
        cap[slot] <= io.bus_data;
    end

    // Snapshot the command phase of each slot at cycle 3
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_valid <= 1'b0;
            smp_cmd   <= 3'd0;
            smp_tag   <= 5'd0;
            smp_addr  <= 26'd0;
        end else if (slot == 3'd3) begin
            smp_valid <= io.bus_valid;
            smp_cmd   <= io.bus_cmd;
            smp_tag   <= io.bus_tag;
            smp_addr  <= io.bus_addr;
        end
    end

    // Slot counter, request latch and transaction FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            slot         <= 3'd0;
            lat_write    <= 1'b0;
            lat_excl     <= 1'b0;
            lat_addr     <= 26'd0;
            lat_wdata    <= 512'd0;
            req_ready_r  <= 1'b1;
            bus_req_r    <= 1'b0;
            cmd_r        <= 3'd0;
            tag_r        <= 5'd0;
            addr_r       <= 26'd0;
            data_r       <= 64'd0;
            resp_valid_r <= 1'b0;
            resp_addr_r  <= 26'd0;
            resp_rdata_r <= 512'd0;
        end else begin
            slot         <= slot + 3'd1;
            resp_valid_r <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (io.req_valid && req_ready_r) begin
                        lat_write   <= io.req_write;
                        lat_excl    <= io.req_excl;
                        lat_addr    <= io.req_addr;
                        lat_wdata   <= io.req_wdata;
                        req_ready_r <= 1'b0;
                        state       <= ARB;
                    end
                end
                ARB: begin
                    // Grant only counts once our request has been visible for a full slot
                    if (slot == 3'd7) begin
                        if (!bus_req_r) begin
                            bus_req_r <= 1'b1;
                        end else if (io.bus_master_grant) begin
                            state     <= SEND;
                            bus_req_r <= 1'b0;
                            cmd_r     <= cmd_sel;
                            tag_r     <= TAG;
                            addr_r    <= lat_addr;
                            data_r    <= lat_write ? lat_wdata[63:0] : 64'd0;
                        end
                    end
                end
                SEND: begin
                    if (slot == 3'd7) begin
                        cmd_r  <= 3'd0;
                        tag_r  <= 5'd0;
                        addr_r <= 26'd0;
                        data_r <= 64'd0;
                        if (io.bus_nack) begin
                            state     <= ARB;
                            bus_req_r <= 1'b1;
                        end else if (lat_write) begin
                            state       <= IDLE;
                            req_ready_r <= 1'b1;
                        end else begin
                            state <= WAIT_FILL;
                        end
                    end else if (lat_write) begin
                        data_r <= lat_wdata[{slot + 3'd1, 6'd0} +: 64];
                    end
                end
                WAIT_FILL: begin
                    // Beat 7 is still on the bus this cycle, so take it directly
                    if ((slot == 3'd7) && fill_hit) begin
                        resp_valid_r <= 1'b1;
                        resp_addr_r  <= lat_addr;
                        resp_rdata_r <= {io.bus_data, cap[6:0]};
                        state        <= IDLE;
                        req_ready_r  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_l2_bus_master.sv
// Directed bench for l2_bus_master: each scenario is described by a few numbers
// (grant delay, nack count, foreign fills, mid-transaction reset) from which the
// expected slot timeline is computed arithmetically and checked every cycle.
module tb_l2_bus_master;

    localparam logic [2:0] CMD_BUSRD  = 3'd1;
    localparam logic [2:0] CMD_BUSRDX = 3'd2;
    localparam logic [2:0] CMD_FLUSH  = 3'd3;
    localparam logic [2:0] CMD_FILL   = 3'd4;
    localparam logic [4:0] TAG        = 5'd0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_bus_master_if ifc ();

    l2_bus_master #(.TAG(TAG)) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc)
    );

    int checks = 0;
    int errors = 0;
    int r      = 0;
    bit active = 1'b0;

    // Scenario description
    int           sc_id;
    bit           sc_write, sc_excl, sc_rst, sc_chain;
    logic [25:0]  sc_addr;
    logic [511:0] sc_wdata;
    logic [63:0]  sc_base;
    int           sc_g, sc_n, sc_f;

    // Cycle (from reset release) whose cycle-7 edge grants send attempt k
    function automatic int gk(input int k);
        return 15 + 8 * sc_g + 16 * k;
    endfunction

    function automatic int cs_end();
        return gk(sc_n) + 8;
    endfunction

    function automatic int fr();
        return cs_end() + 9 + 8 * sc_f;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s sc=%0d r=%0d got %0h want %0h", name, sc_id, r, act, exp);
        end
    endtask

    task automatic drive_cycle();
        int s;
        rst = 1'b0;
        ifc.req_valid = (r == 2) || (sc_chain && r == fr());
        ifc.bus_master_grant = (r == 7) || (r == 20);
        for (int k = 0; k <= sc_n; k++) if (r == gk(k)) ifc.bus_master_grant = 1'b1;
        ifc.bus_nack = (r == 7);
        for (int k = 0; k < sc_n; k++) if (r == gk(k) + 8) ifc.bus_nack = 1'b1;
        ifc.bus_valid = 1'b0;
        ifc.bus_cmd   = 3'd0;
        ifc.bus_tag   = 5'd0;
        ifc.bus_addr  = 26'd0;
        ifc.bus_data  = 64'hDEAD000000000000 + 64'(r);
        // Matching fills while arbitrating or sending must be ignored
        if (!sc_write && (r == 11 || r == gk(0) + 4)) begin
            ifc.bus_valid = 1'b1;
            ifc.bus_cmd   = CMD_FILL;
            ifc.bus_tag   = TAG;
            ifc.bus_addr  = sc_addr;
        end
        if (!sc_write && !sc_rst) begin
            for (int j = 0; j <= sc_f; j++) begin
                s = cs_end() + 1 + 8 * j;
                if (r >= s && r < s + 8) begin
                    if (j == sc_f) ifc.bus_data = sc_base + 64'(r - s);
                    else ifc.bus_data = 64'hBAD0000000000000 + 64'(j * 256 + r - s);
                end
                if (r == s + 3) begin
                    ifc.bus_valid = 1'b1;
                    ifc.bus_cmd   = CMD_FILL;
                    ifc.bus_tag   = (j < sc_f && j % 2 == 0) ? TAG + 5'd1 : TAG;
                    ifc.bus_addr  = (j < sc_f && j % 2 == 1) ? sc_addr + 26'd1 : sc_addr;
                end
            end
        end
        if (sc_rst) begin
            rst = (r == cs_end() + 2);
            s = cs_end() + 3;
            if (r >= s && r < s + 8) ifc.bus_data = sc_base + 64'(r - s);
            if (r == s + 3) begin
                ifc.bus_valid = 1'b1;
                ifc.bus_cmd   = CMD_FILL;
                ifc.bus_tag   = TAG;
                ifc.bus_addr  = sc_addr;
            end
        end
    endtask

    task automatic run_sc(input int id, input bit wr, input bit ex, input logic [25:0] addr,
                          input logic [63:0] wbase, input logic [63:0] fbase,
                          input int g, input int n, input int f, input bit rs, input bit ch);
        int last;
        sc_id = id; sc_write = wr; sc_excl = ex; sc_addr = addr; sc_base = fbase;
        sc_g = g; sc_n = n; sc_f = f; sc_rst = rs; sc_chain = ch;
        for (int k = 0; k < 8; k++) sc_wdata[k*64 +: 64] = wbase + 64'(k);
        ifc.req_write = wr;
        ifc.req_excl  = ex;
        ifc.req_addr  = addr;
        ifc.req_wdata = sc_wdata;
        ifc.req_valid = 1'b0;
        ifc.bus_valid = 1'b0;
        ifc.bus_nack  = 1'b0;
        ifc.bus_master_grant = 1'b0;
        active = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        r = 0;
        if (wr) last = cs_end() + 6;
        else if (rs) last = cs_end() + 20;
        else if (ch) last = fr() + 16;
        else last = fr() + 4;
        drive_cycle();
        active = 1'b1;
        while (r < last) begin
            @(posedge clk);
            #1;
            r = r + 1;
            drive_cycle();
        end
        @(posedge clk);
        #1;
        active = 1'b0;
    endtask

    logic         e_ready, e_req, e_rv;
    logic [2:0]   e_cmd;
    logic [4:0]   e_tag;
    logic [25:0]  e_addr;
    logic [63:0]  e_data;
    logic [511:0] e_rdata;

    // Compare DUT outputs against the slot-timeline model on every cycle
    always @(negedge clk) begin
        if (active) begin
            e_ready = 1'b0; e_req = 1'b0; e_rv = 1'b0;
            e_cmd = 3'd0; e_tag = 5'd0; e_addr = 26'd0; e_data = 64'd0;
            if (sc_rst && r >= cs_end() + 3) begin
                e_ready = 1'b1;
            end else begin
                e_ready = (r <= 2) || (sc_write ? (r >= cs_end() + 1)
                                                : (r >= fr() && !(sc_chain && r > fr())));
                if (r >= 8 && r <= gk(0)) e_req = 1'b1;
                for (int k = 1; k <= sc_n; k++)
                    if (r >= gk(k - 1) + 9 && r <= gk(k)) e_req = 1'b1;
                if (sc_chain && r >= fr() + 8) e_req = 1'b1;
                for (int k = 0; k <= sc_n; k++) begin
                    if (r >= gk(k) + 1 && r <= gk(k) + 8) begin
                        e_cmd  = sc_write ? CMD_FLUSH : (sc_excl ? CMD_BUSRDX : CMD_BUSRD);
                        e_tag  = TAG;
                        e_addr = sc_addr;
                        e_data = sc_write ? sc_wdata[(r - gk(k) - 1) * 64 +: 64] : 64'd0;
                    end
                end
                e_rv = !sc_write && (r == fr());
            end
            chk("req_ready", 512'(ifc.req_ready), 512'(e_ready));
            chk("bus_req", 512'(ifc.master_bus_req), 512'(e_req));
            chk("bus_cmd", 512'(ifc.master_bus_cmd), 512'(e_cmd));
            chk("bus_tag", 512'(ifc.master_bus_tag), 512'(e_tag));
            chk("bus_addr", 512'(ifc.master_bus_addr), 512'(e_addr));
            chk("bus_data", 512'(ifc.master_bus_data), 512'(e_data));
            chk("resp_valid", 512'(ifc.resp_valid), 512'(e_rv));
            if (e_rv) begin
                for (int k = 0; k < 8; k++) e_rdata[k*64 +: 64] = sc_base + 64'(k);
                chk("resp_addr", 512'(ifc.resp_addr), 512'(sc_addr));
                chk("resp_rdata", ifc.resp_rdata, e_rdata);
            end
            // Hand-computed pins of the timeline
            case (sc_id)
                1: begin
                    if (r == 0) chk("pin_rst_ready", 512'(ifc.req_ready), 512'd1);
                    if (r == 16) chk("pin_busrd", 512'(ifc.master_bus_cmd), 512'(CMD_BUSRD));
                    if (r == 32) begin
                        chk("pin_rv", 512'(ifc.resp_valid), 512'd1);
                        chk("pin_raddr", 512'(ifc.resp_addr), 512'h0800000);
                        chk("pin_rdata", ifc.resp_rdata,
                            {64'h7, 64'h6, 64'h5, 64'h4, 64'h3, 64'h2, 64'h1, 64'h0});
                    end
                end
                2: begin
                    if (r == 16) chk("pin_wb_beat0", 512'(ifc.master_bus_data), 512'hA0);
                    if (r == 23) chk("pin_wb_beat7", 512'(ifc.master_bus_data), 512'hA7);
                    if (r == 23) chk("pin_wb_busy", 512'(ifc.req_ready), 512'd0);
                    if (r == 24) chk("pin_wb_ready", 512'(ifc.req_ready), 512'd1);
                    if (r == 24) chk("pin_wb_cmd0", 512'(ifc.master_bus_cmd), 512'd0);
                end
                3: begin
                    if (r == 47) chk("pin_nack_req", 512'(ifc.master_bus_req), 512'd1);
                    if (r == 48) chk("pin_nack_cmd", 512'(ifc.master_bus_cmd), 512'(CMD_BUSRDX));
                    if (r == 64) chk("pin_nack_rv", 512'(ifc.resp_valid), 512'd1);
                end
                4: begin
                    if (r == 39) chk("pin_gd_req", 512'(ifc.master_bus_req), 512'd1);
                    if (r == 39) chk("pin_gd_idle", 512'(ifc.master_bus_cmd), 512'd0);
                    if (r == 40) chk("pin_gd_drop", 512'(ifc.master_bus_req), 512'd0);
                    if (r == 40) chk("pin_gd_cmd", 512'(ifc.master_bus_cmd), 512'(CMD_BUSRDX));
                end
                5: begin
                    if (r == 32 || r == 40) chk("pin_ff_quiet", 512'(ifc.resp_valid), 512'd0);
                    if (r == 48) chk("pin_ff_rv", 512'(ifc.resp_valid), 512'd1);
                end
                6: begin
                    if (r == 26) chk("pin_rst_ready2", 512'(ifc.req_ready), 512'd1);
                    if (r == 34) chk("pin_rst_norv", 512'(ifc.resp_valid), 512'd0);
                end
                default: ;
            endcase
        end
    end

    initial begin
        ifc.req_valid = 1'b0; ifc.req_write = 1'b0; ifc.req_excl = 1'b0;
        ifc.req_addr = 26'd0; ifc.req_wdata = 512'd0;
        ifc.bus_valid = 1'b0; ifc.bus_nack = 1'b0; ifc.bus_cmd = 3'd0; ifc.bus_tag = 5'd0;
        ifc.bus_addr = 26'd0; ifc.bus_data = 64'd0; ifc.bus_master_grant = 1'b0;
        //     id wr ex addr          wbase      fbase                 g  n  f  rs ch
        run_sc(1, 0, 0, 26'h0800000, 64'h0,     64'h0,                0, 0, 0, 0, 1);
        run_sc(2, 1, 0, 26'h0123456, 64'hA0,    64'h0,                0, 0, 0, 0, 0);
        run_sc(3, 0, 1, 26'h2ABCDEF, 64'h0,     64'h1111000000000000, 0, 2, 0, 0, 0);
        run_sc(4, 0, 1, 26'h0000040, 64'h0,     64'h4400,             3, 0, 0, 0, 0);
        run_sc(5, 0, 0, 26'h1FFFFFF, 64'h0,     64'h55000000,         0, 0, 2, 0, 0);
        run_sc(6, 0, 0, 26'h0000001, 64'h0,     64'h6600,             0, 0, 0, 1, 0);
        run_sc(7, 1, 0, 26'h0345678, 64'hC000,  64'h0,                1, 1, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
